conv_out_collector: RTL
=======================

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 Parameter IMG_Width, 7, input image width in pixels.
REQ-002 Parameter IMG_Height, 7, input image height in pixels.
REQ-003 Parameter Datawidth, 16, width of the pixel and result words.
REQ-004 Parameter Stride, 1, convolution stride; OUT_W = ceil(IMG_Width/Stride), OUT_H = ceil(IMG_Height/Stride), DEPTH = OUT_W*OUT_H.
REQ-005 CLK  in  1  single clock; all state changes on its rising edge.
REQ-006 CLR  in  1  reset; asynchronous and active-low.
REQ-007 Start  in  1  arms collection of one frame; sampled in IDLE only.
REQ-008 Valid_IN  in  1  result beat valid; driven by the conv block's Valid_OUT.
REQ-009 In  in  Datawidth  result word; driven by the conv block's Out.
REQ-010 Out_Ready  in  1  downstream consumer ready.
REQ-011 Out_Valid  out  1  Out holds a valid stored result.
REQ-012 Out  out  Datawidth  stored result in raster order.
REQ-013 Out_Last  out  1  high with the final beat (index DEPTH-1) of a frame.
REQ-014 Frame_Done  out  1  one-cycle pulse when the frame is fully captured.
REQ-015 Overflow  out  1  sticky; a beat arrived while DRAIN was active.
REQ-016 Busy  out  1  high in COLLECT and DRAIN.

Function
REQ-017 The FSM SHALL have the states IDLE, COLLECT and DRAIN, with reset state IDLE.
REQ-018 In IDLE, Start=1 SHALL move the FSM to COLLECT with wr_ptr=0; a Valid_IN beat in IDLE, including one in the same cycle as Start, SHALL be discarded without setting Overflow.
REQ-019 In COLLECT, each cycle with Valid_IN=1 SHALL write In to mem[wr_ptr] and increment wr_ptr; gaps in Valid_IN SHALL be tolerated with no timeout.
REQ-020 On the write where wr_ptr=DEPTH-1, the FSM SHALL enter DRAIN and Frame_Done SHALL pulse high for exactly the next cycle.
REQ-021 In DRAIN, rd_ptr SHALL start at 0; Out_Valid SHALL rise one cycle after DRAIN entry (registered RAM read), with Out=mem[rd_ptr].
REQ-022 A transfer SHALL occur when Out_Valid=1 and Out_Ready=1; rd_ptr then advances, and the next word SHALL be presented with no bubble cycle.
REQ-023 While Out_Valid=1 and Out_Ready=0, Out, Out_Last and Out_Valid SHALL hold stable.
REQ-024 Out_Last SHALL equal (rd_ptr==DEPTH-1) while Out_Valid=1 and SHALL be 0 otherwise.
REQ-025 After the Out_Last transfer, Out_Valid SHALL drop in the next cycle and the FSM SHALL return to IDLE.
REQ-026 Valid_IN in DRAIN SHALL set Overflow, discard the beat and leave stored data untouched.
REQ-027 Overflow SHALL clear only on reset or on Start accepted in IDLE.
REQ-028 Start in COLLECT or DRAIN SHALL be ignored.
REQ-029 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits wide and SHALL never address beyond DEPTH-1.
REQ-030 Data SHALL pass through unmodified (no sign handling, no truncation).

Reset
REQ-031 CLR=0 SHALL immediately force state IDLE, wr_ptr=0, rd_ptr=0, Out_Valid=0, Out=0, Out_Last=0, Frame_Done=0, Overflow=0 and Busy=0.
REQ-032 RAM contents SHALL not be reset; a reset in the middle of COLLECT or DRAIN SHALL abandon the frame, and the next Start SHALL begin writing at address 0.

Structure
REQ-033 OUT_W, OUT_H, DEPTH and the state encoding SHALL be defined in the shared CNN package.
REQ-034 Storage SHALL be one sub-module, frame_buffer_ram, a simple dual-port RAM with one write port, one read port, registered read and DEPTH x Datawidth capacity.

Verification
REQ-035 Test 7x7, Stride=1: Start, then values 1..49 with random gaps -> Frame_Done pulses once after beat 49; with Out_Ready=1, Out yields 1..49 and Out_Last is high only on 49.
REQ-036 Test backpressure: Out_Ready toggles 1,0,0,1 during drain -> no loss or duplication, and Out is stable while stalled.
REQ-037 Test overflow: 3 Valid_IN beats of 0xFFFF during DRAIN -> Overflow=1, drain still yields 1..49, and the next Start clears Overflow.
REQ-038 Test reset mid-frame: CLR=0 after 20 collected beats -> all outputs 0 and state IDLE; a new frame of 100..148 then drains as 100..148.
REQ-039 Test Stride=2, 7x7: DEPTH=16; 16 beats -> Frame_Done; a 17th beat sets Overflow.
REQ-040 Test idle beats: Valid_IN pulses before Start are discarded and Overflow stays 0.

Source files
------------

// File: rtl/conv_out_collector_pkg.sv
// conv_out_collector_pkg: shared CNN types and output-geometry helpers
package conv_out_collector_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  function automatic int out_w(input int img_w, input int stride);
    return (img_w + stride - 1) / stride;
  endfunction
  function automatic int out_h(input int img_h, input int stride);
    return (img_h + stride - 1) / stride;
  endfunction
  function automatic int frame_depth(input int img_w, input int img_h, input int stride);
    return out_w(img_w, stride) * out_h(img_h, stride);
  endfunction
endpackage

// File: rtl/conv_out_collector_frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port RAM, one write port, one registered read port
// Ports: CLK; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data one cycle later.
module frame_buffer_ram #(
  parameter int DEPTH = 49,
  parameter int Datawidth = 16,
  parameter int AW = 6
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [Datawidth-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [Datawidth-1:0] rd_data
);
  logic [Datawidth-1:0] mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/conv_out_collector.sv
// conv_out_collector: buffers one conv output frame, then drains it in raster order
// Ports: CLK, CLR (async active-low); Start arms a frame; Valid_IN/In capture beats;
// Out_Valid/Out_Ready/Out/Out_Last drain stream; Frame_Done pulse; Overflow sticky; Busy.
module conv_out_collector import conv_out_collector_pkg::*; #(
  parameter int IMG_Width = 7,
  parameter int IMG_Height = 7,
  parameter int Datawidth = 16,
  parameter int Stride = 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 Start,
  input  logic                 Valid_IN,
  input  logic [Datawidth-1:0] In,
  input  logic                 Out_Ready,
  output logic                 Out_Valid,
  output logic [Datawidth-1:0] Out,
  output logic                 Out_Last,
  output logic                 Frame_Done,
  output logic                 Overflow,
  output logic                 Busy
);
  localparam int DEPTH = frame_depth(IMG_Width, IMG_Height, Stride);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [Datawidth-1:0] rd_data;
  logic wr_en, wr_last, fire, rd_last;
  assign wr_en = state == COLLECT && Valid_IN;
  assign wr_last = wr_en && wr_ptr == LAST;
  assign fire = Out_Valid && Out_Ready;
  assign rd_last = rd_ptr == LAST;
  // Look one word ahead on a transfer so the registered read has the next word ready without a bubble.
  assign rd_addr = fire && !rd_last ? rd_ptr + AW'(1) : rd_ptr;
  assign Out_Last = Out_Valid && rd_last;
  // RAM output is not reset, so gate it to keep Out at zero whenever nothing is presented.
  assign Out = Out_Valid ? rd_data : '0;
  assign Busy = state != IDLE;
  always_comb
    state_n = state == IDLE    ? (Start ? COLLECT : IDLE) :
              state == COLLECT ? (wr_last ? DRAIN : COLLECT) :
                                 (fire && rd_last ? IDLE : DRAIN);
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Out_Valid <= 1'b0;
      Frame_Done <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      wr_ptr <= state != COLLECT || wr_last ? '0 : wr_ptr + AW'(wr_en);
      rd_ptr <= state != DRAIN || (fire && rd_last) ? '0 : rd_ptr + AW'(fire);
      // The first DRAIN cycle only issues the read of word 0; valid follows one cycle later.
      Out_Valid <= state == DRAIN && !(fire && rd_last);
      Frame_Done <= wr_last;
      Overflow <= state == IDLE && Start ? 1'b0 : Overflow | (state == DRAIN && Valid_IN);
    end
  frame_buffer_ram #(.DEPTH(DEPTH), .Datawidth(Datawidth), .AW(AW)) u_ram (
    .CLK(CLK),
    .wr_en(wr_en),
    .wr_addr(wr_ptr),
    .wr_data(In),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule
